// File: rtl/dc_fu_dma_pkg.sv
// ============================================================================
// dc_fu_dma_pkg : shared constants, FSM state type and log2 helper
// Revision: 1.0
// ============================================================================
`default_nettype none

package dc_fu_dma_pkg;

    localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
    localparam int unsigned AXI_4K_BYTES   = 4096;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        REQ   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    function automatic int unsigned log2_int(input int unsigned value);
        int unsigned v;
        int unsigned r;
        v = value;
        r = 0;
        while (v > 1) begin
            v = v >> 1;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dc_fu_dma_burst_len_calc.sv
// ============================================================================
// dc_fu_dma_burst_len_calc : min(remaining, MAX_BURST_LEN, beats_to_4k)
// Revision: 1.0
// ============================================================================
`default_nettype none

module dc_fu_dma_burst_len_calc #(
    parameter int FETCH_WORD_COUNT_WIDTH = 16,
    parameter int MAX_BURST_LEN          = 16
) (
    input  logic [FETCH_WORD_COUNT_WIDTH-1:0] remaining,
    input  logic [12:0]                       beats_to_4k,
    output logic [8:0]                        len
);

    // Compare at a common width so a narrow word count never truncates the 4 KB limit.
    localparam int CMP_W = (FETCH_WORD_COUNT_WIDTH > 13) ? FETCH_WORD_COUNT_WIDTH : 13;
    localparam logic [CMP_W-1:0] MAX_LEN = CMP_W'(MAX_BURST_LEN);

    logic [CMP_W-1:0] rem_w;
    logic [CMP_W-1:0] b4k_w;
    logic [CMP_W-1:0] cap_w;

    always_comb begin
        rem_w = CMP_W'(remaining);
        b4k_w = CMP_W'(beats_to_4k);
        cap_w = (b4k_w < MAX_LEN) ? b4k_w : MAX_LEN;
        len   = 9'((rem_w < cap_w) ? rem_w : cap_w);
    end

endmodule

`default_nettype wire

// File: rtl/dc_fu_dma_read_request_generator.sv
// ============================================================================
// dc_fu_dma_read_request_generator : splits fetch commands into 4 KB-safe AXI INCR reads
// Revision: 1.0
// ============================================================================
`default_nettype none

module dc_fu_dma_read_request_generator
    import dc_fu_dma_pkg::*;
#(
    parameter int ADDR_WIDTH             = 32,
    parameter int DATA_BYTES             = 16,
    parameter int FETCH_WORD_COUNT_WIDTH = 16,
    parameter int MAX_BURST_LEN          = 16
) (
    input  logic                              clk,
    input  logic                              nrst,
    input  logic                              en,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic [ADDR_WIDTH-1:0]             cmd_addr,
    input  logic [FETCH_WORD_COUNT_WIDTH-1:0] cmd_word_count,
    output logic                              start_fetch,
    output logic [FETCH_WORD_COUNT_WIDTH-1:0] fetch_word_count,
    input  logic                              fetch_in_progress,
    output logic                              axi_arvalid,
    input  logic                              axi_arready,
    output logic [ADDR_WIDTH-1:0]             axi_araddr,
    output logic [7:0]                        axi_arlen,
    output logic [2:0]                        axi_arsize,
    output logic [1:0]                        axi_arburst,
    output logic                              busy
);

    localparam int unsigned             SIZE_LOG2  = log2_int(DATA_BYTES);
    localparam logic [ADDR_WIDTH-1:0]   ALIGN_MASK = ~(ADDR_WIDTH'(DATA_BYTES - 1));

    state_t                              state;
    state_t                              state_next;
    logic [ADDR_WIDTH-1:0]               cur_addr;
    logic [ADDR_WIDTH-1:0]               cur_addr_next;
    logic [FETCH_WORD_COUNT_WIDTH-1:0]   remaining;
    logic [FETCH_WORD_COUNT_WIDTH-1:0]   remaining_next;
    logic [FETCH_WORD_COUNT_WIDTH-1:0]   fetch_word_count_next;
    logic                                start_fetch_next;
    logic                                arvalid_next;
    logic [ADDR_WIDTH-1:0]               araddr_next;
    logic [7:0]                          arlen_next;
    logic [12:0]                         beats_to_4k;
    logic [8:0]                          burst_len;
    logic [8:0]                          issued_beats;

    // cur_addr is always beat-aligned, so the division is an exact shift.
    assign beats_to_4k  = 13'((13'(AXI_4K_BYTES) - {1'b0, cur_addr[11:0]}) >> SIZE_LOG2);
    assign issued_beats = {1'b0, axi_arlen} + 9'd1;

    dc_fu_dma_burst_len_calc #(
        .FETCH_WORD_COUNT_WIDTH (FETCH_WORD_COUNT_WIDTH),
        .MAX_BURST_LEN          (MAX_BURST_LEN)
    ) u_burst_len_calc (
        .remaining   (remaining),
        .beats_to_4k (beats_to_4k),
        .len         (burst_len)
    );

    assign cmd_ready   = nrst && en && !fetch_in_progress && (state == IDLE);
    assign busy        = (state != IDLE);
    assign axi_arsize  = 3'(SIZE_LOG2);
    assign axi_arburst = AXI_BURST_INCR;

    always_comb begin
        state_next            = state;
        cur_addr_next         = cur_addr;
        remaining_next        = remaining;
        fetch_word_count_next = fetch_word_count;
        start_fetch_next      = 1'b0;
        arvalid_next          = axi_arvalid;
        araddr_next           = axi_araddr;
        arlen_next            = axi_arlen;

        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    cur_addr_next         = cmd_addr & ALIGN_MASK;
                    remaining_next        = cmd_word_count;
                    fetch_word_count_next = cmd_word_count;
                    if (cmd_word_count != '0) begin
                        start_fetch_next = 1'b1;
                        state_next       = CALC;
                    end
                end
            end
            CALC: begin
                if (en) begin
                    araddr_next  = cur_addr;
                    arlen_next   = 8'(burst_len - 9'd1);
                    arvalid_next = 1'b1;
                    state_next   = REQ;
                end
            end
            REQ: begin
                // A pending request completes even with en low; the transition then waits for en.
                if (axi_arvalid) begin
                    if (axi_arready) begin
                        arvalid_next   = 1'b0;
                        cur_addr_next  = cur_addr + (ADDR_WIDTH'(issued_beats) << SIZE_LOG2);
                        remaining_next = remaining - FETCH_WORD_COUNT_WIDTH'(issued_beats);
                        if (en) begin
                            state_next = (remaining_next == '0) ? DRAIN : CALC;
                        end
                    end
                end else if (en) begin
                    state_next = (remaining == '0) ? DRAIN : CALC;
                end
            end
            DRAIN: begin
                if (en && !fetch_in_progress) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state            <= IDLE;
            cur_addr         <= '0;
            remaining        <= '0;
            fetch_word_count <= '0;
            start_fetch      <= 1'b0;
            axi_arvalid      <= 1'b0;
            axi_araddr       <= '0;
            axi_arlen        <= '0;
        end else begin
            state            <= state_next;
            cur_addr         <= cur_addr_next;
            remaining        <= remaining_next;
            fetch_word_count <= fetch_word_count_next;
            start_fetch      <= start_fetch_next;
            axi_arvalid      <= arvalid_next;
            axi_araddr       <= araddr_next;
            axi_arlen        <= arlen_next;
        end
    end

endmodule

`default_nettype wire

// File: doc/dc_fu_dma_read_request_generator.md
Name: dc_fu_dma_read_request_generator

Overview:
Upstream neighbour of the DMA fetching progress counter in the fetching unit.
- Accepts one fetch command (byte address, word count) at a time.
- Splits it into AXI4 INCR read bursts that respect a maximum burst length and never cross a 4 KB boundary, and issues them on the AR channel.
- Emits the start_fetch pulse and fetch_word_count consumed by the progress counter.
- Uses the returned fetch_in_progress to decide when the command is fully retired.

Parameters:
ADDR_WIDTH, 32, AXI address width.
DATA_BYTES, 16, bytes per AXI beat (one fetch word); power of two, 1..128.
FETCH_WORD_COUNT_WIDTH, 16, width of word counts; must match the progress counter.
MAX_BURST_LEN, 16, maximum beats per burst; 1..256.

Ports:
clk  in  1  clock
nrst  in  1  asynchronous active-low reset
en  in  1  global enable; 0 stalls the FSM (see AR rule below)
cmd_valid  in  1  fetch command valid
cmd_ready  out  1  block can accept a command
cmd_addr  in  ADDR_WIDTH  start byte address; low log2(DATA_BYTES) bits ignored, treated as 0
cmd_word_count  in  FETCH_WORD_COUNT_WIDTH  number of words to fetch
start_fetch  out  1  one-cycle pulse to the progress counter
fetch_word_count  out  FETCH_WORD_COUNT_WIDTH  latched word count, valid while start_fetch=1
fetch_in_progress  in  1  from progress counter; 1 while beats remain outstanding
axi_arvalid  out  1  AR valid
axi_arready  in  1  AR ready
axi_araddr  out  ADDR_WIDTH  burst start address
axi_arlen  out  8  beats-1
axi_arsize  out  3  constant log2(DATA_BYTES)
axi_arburst  out  2  constant 2'b01 (INCR)
busy  out  1  1 in any state other than IDLE

Behaviour:
- Reset is asynchronous on nrst, active-low, on clk.
- Reset values: state IDLE, cmd_ready=0 during reset, start_fetch=0, fetch_word_count=0, axi_arvalid=0, axi_araddr=0, axi_arlen=0, busy=0.
- States: IDLE, CALC, REQ, DRAIN.
- IDLE:
  - cmd_ready = en && !fetch_in_progress.
  - On cmd_valid && cmd_ready: latch the aligned address as cur_addr, latch the count as remaining and fetch_word_count.
  - If count != 0: register start_fetch=1 for exactly the next cycle and go to CALC.
  - If count == 0: no pulse, no bursts, stay in IDLE. The command is consumed.
- CALC (one cycle): compute
  - beats_to_4k = (4096 - cur_addr[11:0]) / DATA_BYTES
  - len = min(remaining, MAX_BURST_LEN, beats_to_4k)
  - Register axi_araddr=cur_addr and axi_arlen=len-1, assert axi_arvalid, go to REQ.
- REQ:
  - axi_arvalid, axi_araddr and axi_arlen stay stable until axi_arready.
  - On handshake: arvalid drops the next cycle, cur_addr += len*DATA_BYTES, remaining -= len.
  - If the new remaining is 0, go to DRAIN; else go to CALC.
  - No back-to-back AR issue: minimum 2 cycles per burst.
- DRAIN: wait for fetch_in_progress==0, then go to IDLE.
- Latency:
  - Accept cycle N: start_fetch high at N+1, arvalid high at N+2.
  - The counter loads at N+1, before any R beat can return.
- en=0:
  - Freezes all state transitions and the CALC/IDLE actions.
  - An already asserted axi_arvalid is never withdrawn; its handshake completes and the FSM then holds in place until en=1.
- Width rules:
  - remaining is FETCH_WORD_COUNT_WIDTH bits; len fits in 9 bits.
  - Address arithmetic wraps modulo 2^ADDR_WIDTH; no error is flagged.
- A command arriving while busy is not accepted: cmd_ready=0.
- Reset mid-operation: all state is cleared immediately. Outstanding AXI transactions are the system's responsibility; the counter is reset by the same nrst.

Decomposition:
- Package dc_fu_dma_pkg holds:
  - AXI_BURST_INCR = 2'b01
  - AXI_4K_BYTES = 4096
  - the state enum (IDLE, CALC, REQ, DRAIN)
  - a log2 helper for arsize
- One sub-module, dc_fu_dma_burst_len_calc: purely combinational three-way min of remaining, MAX_BURST_LEN and beats_to_4k.

Test Plan:
- Cmd addr 0x1000, count 40 (DATA_BYTES 16, MAX 16), arready tied 1:
  - start_fetch one cycle with fetch_word_count=40.
  - Bursts (0x1000, arlen 15), (0x1100, 15), (0x1200, 7).
  - DRAIN until fetch_in_progress falls, then busy=0.
- Cmd addr 0x0FC0, count 8:
  - Bursts (0x0FC0, arlen 3), (0x1000, arlen 3); no 4 KB crossing.
- arready held low 5 cycles during the first burst:
  - arvalid, araddr and arlen are stable all 5 cycles.
  - Exactly one handshake occurs.
- Count 0 command: accepted (cmd_ready=1), no start_fetch, no arvalid, busy stays 0.
- cmd_valid held while busy and while fetch_in_progress=1: cmd_ready=0 throughout; accepted the cycle after DRAIN exits.
- Stall and reset cases:
  - en=0 while arvalid=1: arvalid stays high until arready, then the FSM freezes.
  - nrst pulse mid-REQ: all outputs return to reset values asynchronously.
